// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared state encoding and sizing helper for seq_chunk_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ceiling log2 with a floor of 1 so a single-chunk counter still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder_if
// Description : Start/done operand and result bundle for seq_chunk_adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
endinterface
`default_nettype wire

// File: rtl/seq_chunk_adder_chunk_ripple_add.sv
`default_nettype none
// ============================================================================
// Module      : chunk_ripple_add
// Description : CHUNK-bit ripple of full-adder cells, exposing the carry into the top bit.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_ripple_add
  import adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[CHUNK];
  assign cmsb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_chunk_adder
// Description : Multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = clog2_min1(NCHUNK);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum_chunk;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_merged;
  logic             w_last;

  assign w_last = (r_idx == IDXW'(NCHUNK - 1));

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_chunk = r_opa[i*CHUNK +: CHUNK];
        w_b_chunk = r_opb[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_ripple_add #(
    .CHUNK (CHUNK)
  ) u_stage (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .sum  (w_sum_chunk),
    .cout (w_cout),
    .cmsb (w_cmsb)
  );

  // Working result with the chunk being processed this cycle already merged in.
  always_comb begin
    w_merged = r_work;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDXW'(i)) w_merged[i*CHUNK +: CHUNK] = w_sum_chunk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work  <= w_merged;
          r_carry <= w_cout;
          if (w_last) begin
            r_sum   <= w_merged;
            r_cout  <= w_cout;
            r_ovf   <= w_cmsb ^ w_cout;
            r_done  <= 1'b1;
            r_idx   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_chunk_adder
// Description : Randomized and directed checks of seq_chunk_adder in three geometries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) if0 ();
  seq_chunk_adder_if #(.WIDTH(16)) if1 ();
  seq_chunk_adder_if #(.WIDTH(8))  if2 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_chunk_adder #(.WIDTH(8),  .CHUNK(1))  u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 2) ? 8 : 16;
  endfunction

  function automatic int nchunk_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
  endfunction

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  task automatic model(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic c, output logic [31:0] es, output logic [31:0] eco,
                       output logic [31:0] eov);
    logic [63:0] mask, aa, bb, full;
    logic        sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    aa   = {48'd0, a} & mask;
    bb   = s ? (~{48'd0, b} & mask) : ({48'd0, b} & mask);
    full = aa + bb + ((s || c) ? 64'd1 : 64'd0);
    es   = 32'(full & mask);
    eco  = {31'd0, full[w]};
    sa   = aa[w-1];
    sb   = bb[w-1];
    ss   = full[w-1];
    eov  = {31'd0, (sa == sb) && (ss != sa)};
  endtask

  task automatic drive(input int sel, input logic st, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic c);
    case (sel)
      0: begin if0.start = st; if0.sub = s; if0.a = a; if0.b = b; if0.cin = c; end
      1: begin if1.start = st; if1.sub = s; if1.a = a; if1.b = b; if1.cin = c; end
      default: begin if2.start = st; if2.sub = s; if2.a = a[7:0]; if2.b = b[7:0]; if2.cin = c; end
    endcase
  endtask

  task automatic sample(input int sel, output logic bz, output logic dn, output logic [31:0] sm,
                        output logic [31:0] co, output logic [31:0] ov);
    case (sel)
      0: begin bz = if0.busy; dn = if0.done; sm = {16'd0, if0.sum}; co = {31'd0, if0.cout}; ov = {31'd0, if0.ovf}; end
      1: begin bz = if1.busy; dn = if1.done; sm = {16'd0, if1.sum}; co = {31'd0, if1.cout}; ov = {31'd0, if1.ovf}; end
      default: begin bz = if2.busy; dn = if2.done; sm = {24'd0, if2.sum}; co = {31'd0, if2.cout}; ov = {31'd0, if2.ovf}; end
    endcase
  endtask

  // Called at a negedge: launches one operation and returns at the negedge where done is seen,
  // so consecutive calls exercise back-to-back acceptance in the done cycle.
  task automatic do_check(input int sel, input string tag, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input logic c, input bit glitch,
                          input logic [31:0] es, input logic [31:0] eco, input logic [31:0] eov);
    logic        bz, dn;
    logic [31:0] sm, co, ov, sm_before;
    int          n, kdone, busyc;
    n = nchunk_of(sel);
    sample(sel, bz, dn, sm_before, co, ov);
    drive(sel, 1'b1, s, a, b, c);
    @(posedge clk);
    kdone = -1;
    busyc = 0;
    for (int k = 1; k <= n + 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, ~s, 16'($urandom), 16'($urandom), ~c);
      if (glitch && k == 2) drive(sel, 1'b1, ~s, ~a, ~b, ~c);
      if (glitch && k == 3) drive(sel, 1'b0, s, a, b, c);
      sample(sel, bz, dn, sm, co, ov);
      if (k == n) chk({tag, "_hold"}, sm, sm_before);
      if (bz) busyc++;
      if (dn) begin
        kdone = k;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(kdone), 32'(n + 1));
    chk({tag, "_busy"}, 32'(busyc), 32'(n));
    chk({tag, "_sum"}, sm, es);
    chk({tag, "_cout"}, co, eco);
    chk({tag, "_ovf"}, ov, eov);
  endtask

  task automatic do_rand(input int sel, input string tag);
    logic        s, c;
    logic [15:0] a, b;
    logic [31:0] es, eco, eov;
    s = 1'($urandom);
    c = 1'($urandom);
    a = 16'($urandom);
    b = 16'($urandom);
    if (sel == 2) begin a[15:8] = 8'd0; b[15:8] = 8'd0; end
    model(width_of(sel), s, a, b, c, es, eco, eov);
    do_check(sel, tag, s, a, b, c, 1'b0, es, eco, eov);
  endtask

  task automatic idle_done_free(input int sel, input string tag);
    logic        bz, dn;
    logic [31:0] sm, co, ov, sm0;
    @(negedge clk);
    sample(sel, bz, dn, sm0, co, ov);
    chk({tag, "_done_drop"}, {31'd0, dn}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bz}, 32'd0);
    @(negedge clk);
    sample(sel, bz, dn, sm, co, ov);
    chk({tag, "_sum_stable"}, sm, sm0);
  endtask

  initial begin
    logic        bz, dn;
    logic [31:0] sm, co, ov;
    int          seen;

    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      sample(i, bz, dn, sm, co, ov);
      chk($sformatf("rst%0d_outs", i), {bz, dn, co[0], ov[0], sm[27:0]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if0.done) seen++;
    end
    chk("idle_no_done", 32'(seen), 32'd0);

    do_check(0, "add_1234", 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 32'h5555, 32'd0, 32'd0);
    idle_done_free(0, "add_1234");
    do_check(0, "add_ffff", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h0000, 32'd1, 32'd0);
    do_check(0, "add_7fff", 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 32'h8000, 32'd0, 32'd1);
    do_check(0, "sub_5_7", 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0, 32'hFFFE, 32'd0, 32'd0);
    do_check(0, "sub_8000", 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, 32'h7FFF, 32'd1, 32'd1);
    do_check(0, "sub_cin1", 1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 32'h7FFF, 32'd1, 32'd1);
    do_check(0, "glitch", 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1, 32'h3333, 32'd0, 32'd0);
    idle_done_free(0, "glitch");

    // Abort in the middle of a run: previous result is nonzero, reset must clear it.
    drive(0, 1'b1, 1'b0, 16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    sample(0, bz, dn, sm, co, ov);
    chk("abort_outs", {bz, dn, co[0], ov[0], sm[27:0]}, 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.done || if0.busy) seen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.done || if0.busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    do_check(0, "post_abort", 1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 32'h1010, 32'd0, 32'd0);

    for (int i = 0; i < 20; i++) do_rand(0, $sformatf("r0_%0d", i));
    idle_done_free(0, "r0");

    do_check(1, "c16_aaaa", 1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 32'h0000, 32'd1, 32'd0);
    for (int i = 0; i < 15; i++) do_rand(1, $sformatf("r1_%0d", i));
    idle_done_free(1, "r1");

    do_check(2, "c1_80", 1'b0, 16'h0080, 16'h0080, 1'b0, 1'b0, 32'h00, 32'd1, 32'd1);
    for (int i = 0; i < 15; i++) do_rand(2, $sformatf("r2_%0d", i));
    idle_done_free(2, "r2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
